// File: rtl/serial_tx_feeder_if.sv
// Bundles the CPU-side word port and the serial_port byte port of serial_tx_feeder.
// master drives words and the transmitter status; slave is the feeder itself.
interface serial_tx_feeder_if;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        wr_full;
    logic        overflow;
    logic        clr_overflow;
    logic [15:0] data_out;
    logic        write_enable;
    logic        write_not_busy;
    logic        idle;

    modport master (
        output wr_data, wr_en, clr_overflow, write_not_busy,
        input  wr_full, overflow, data_out, write_enable, idle
    );

    modport slave (
        input  wr_data, wr_en, clr_overflow, write_not_busy,
        output wr_full, overflow, data_out, write_enable, idle
    );
endinterface

// File: rtl/serial_tx_feeder.sv
// Word-to-byte feeder: buffers 32-bit words in a FIFO and strobes them out one byte at a time.
// Latency: push into an empty idle block -> write_enable 3 cycles later; strobes at least 3 cycles apart.
// Backpressure: bytes wait on write_not_busy; pushes while wr_full are dropped and flag overflow.
// SERIAL_TX_MSB_FIRST_EN defined: bytes leave MSB first; otherwise LSB first.
module serial_tx_feeder #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic               clk,
    input  logic               rst,
    serial_tx_feeder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STROBE, ST_HOLD} state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           mem_d [DEPTH];
    logic [31:0]           shift_q, shift_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [15:0]           data_out_q, data_out_d;
    logic                  write_enable_q, write_enable_d;
    logic                  overflow_q, overflow_d;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic [7:0]            cur_byte;

    // Full only from registered pointers, so a same-cycle pop never frees a slot for a push.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                        (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign push       = bus.wr_en && !fifo_full;

    always_comb begin
        cur_byte = 8'h00;
`ifdef SERIAL_TX_MSB_FIRST_EN
        case (byte_idx_q)
            2'd0:    cur_byte = shift_q[31:24];
            2'd1:    cur_byte = shift_q[23:16];
            2'd2:    cur_byte = shift_q[15:8];
            default: cur_byte = shift_q[7:0];
        endcase
`else
        case (byte_idx_q)
            2'd0:    cur_byte = shift_q[7:0];
            2'd1:    cur_byte = shift_q[15:8];
            2'd2:    cur_byte = shift_q[23:16];
            default: cur_byte = shift_q[31:24];
        endcase
`endif
    end

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        byte_idx_d     = byte_idx_q;
        data_out_d     = data_out_q;
        write_enable_d = 1'b0;
        pop            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
                    byte_idx_d = 2'd0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.write_not_busy) begin
                    data_out_d     = {8'h00, cur_byte};
                    write_enable_d = 1'b1;
                    state_d        = ST_STROBE;
                end
            end
            ST_STROBE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // The transmitter's busy flag lags the strobe, so it is not looked at here.
                if (byte_idx_q != 2'd3) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    state_d    = ST_WAIT;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
                    byte_idx_d = 2'd0;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = bus.wr_data;
            wr_ptr_d = wr_ptr_q + (DEPTH_LOG2+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (DEPTH_LOG2+1)'(1);
        end
        if (bus.wr_en && fifo_full) begin
            overflow_d = 1'b1;
        end else if (bus.clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            shift_q        <= '0;
            byte_idx_q     <= '0;
            data_out_q     <= '0;
            write_enable_q <= 1'b0;
            overflow_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            shift_q        <= shift_d;
            byte_idx_q     <= byte_idx_d;
            data_out_q     <= data_out_d;
            write_enable_q <= write_enable_d;
            overflow_q     <= overflow_d;
            mem_q          <= mem_d;
        end
    end

    assign bus.wr_full      = fifo_full;
    assign bus.overflow     = overflow_q;
    assign bus.data_out     = data_out_q;
    assign bus.write_enable = write_enable_q;
    assign bus.idle         = (state_q == ST_IDLE) && fifo_empty;
endmodule

// File: tb/tb_serial_tx_feeder.sv
// Bench for serial_tx_feeder: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations on strobe data and timing.
module tb_serial_tx_feeder;
    localparam int DEPTH = 8;
`ifdef SERIAL_TX_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    logic clk;
    logic rst;

    serial_tx_feeder_if bus();

    serial_tx_feeder #(.DEPTH_LOG2(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: words waiting, bytes of the word in hand, and the cycle numbers
    // at which the next strobe / end-of-word decision / next eligible busy sample fall.
    logic [31:0] m_fifo [$];
    logic [7:0]  m_pend [$];
    int          m_strobe_at;
    int          m_last_hold;
    int          m_next_ok;
    logic [15:0] m_dout;
    logic        m_ovf;
    bit          m_full;
    bit          m_idle_st;
    bit          do_pop;
    bit          do_push;
    int          cyc = 0;

    int          strobe_cyc [$];
    logic [15:0] strobe_dat [$];
    int          push_cyc [$];
    int          last_idle_rise = -1;
    logic        idle_prev = 1'b0;
    logic        we_seen = 1'b0;

    task automatic m_reset();
        m_fifo.delete();
        m_pend.delete();
        m_strobe_at = -1;
        m_last_hold = -1;
        m_next_ok   = 0;
        m_dout      = '0;
        m_ovf       = 1'b0;
    endtask

    task automatic m_load(input logic [31:0] w);
        m_pend.delete();
        for (int i = 0; i < 4; i++) begin
            if (MSB_FIRST) m_pend.push_back(w[8*(3-i) +: 8]);
            else           m_pend.push_back(w[8*i +: 8]);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_reset();
            chk("rst_write_enable", bus.write_enable, 1'b0);
            chk("rst_data_out", bus.data_out, 16'h0000);
            chk("rst_wr_full", bus.wr_full, 1'b0);
            chk("rst_overflow", bus.overflow, 1'b0);
            chk("rst_idle", bus.idle, 1'b1);
        end else begin
            m_full    = (m_fifo.size() == DEPTH);
            m_idle_st = (m_pend.size() == 0) && (m_strobe_at != cyc) && (m_last_hold != cyc);
            chk("write_enable", bus.write_enable, m_strobe_at == cyc);
            chk("data_out", bus.data_out, m_dout);
            chk("wr_full", bus.wr_full, m_full);
            chk("overflow", bus.overflow, m_ovf);
            chk("idle", bus.idle, m_idle_st && (m_fifo.size() == 0));
            if (bus.write_enable) begin
                strobe_cyc.push_back(cyc);
                strobe_dat.push_back(bus.data_out);
            end
            if (bus.idle && !idle_prev) last_idle_rise = cyc;

            do_pop  = (m_fifo.size() != 0) && (m_idle_st || m_last_hold == cyc);
            do_push = bus.wr_en && !m_full;
            if (do_push) push_cyc.push_back(cyc);
            if (bus.wr_en && m_full) m_ovf = 1'b1;
            else if (bus.clr_overflow) m_ovf = 1'b0;
            if (do_pop) begin
                m_load(m_fifo.pop_front());
                m_next_ok = cyc + 1;
            end else if (m_pend.size() != 0 && cyc >= m_next_ok && bus.write_not_busy) begin
                m_dout      = {8'h00, m_pend.pop_front()};
                m_strobe_at = cyc + 1;
                m_next_ok   = cyc + 3;
                if (m_pend.size() == 0) m_last_hold = cyc + 2;
            end
            if (do_push) m_fifo.push_back(bus.wr_data);
        end
        idle_prev = bus.idle;
        we_seen   = bus.write_enable;
        cyc++;
    end

    // write_not_busy source: 0 = fixed level, 1 = busy for 10 cycles after each strobe, 2 = random.
    int   wnb_mode  = 0;
    logic wnb_fixed = 1'b1;
    int   busy      = 0;

    always @(posedge clk) begin
        #1;
        case (wnb_mode)
            0: bus.write_not_busy = wnb_fixed;
            1: begin
                if (we_seen) busy = 10;
                bus.write_not_busy = (busy == 0);
                if (busy > 0) busy--;
            end
            default: bus.write_not_busy = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        bus.wr_data = w;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic clear_logs();
        strobe_cyc.delete();
        strobe_dat.delete();
        push_cyc.delete();
    endtask

    task automatic wait_strobes(input int n, input int budget, input string name);
        int k = 0;
        while (strobe_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_strobes_seen"}, strobe_cyc.size() >= n, 1'b1);
    endtask

    function automatic logic [15:0] t6_exp(input int i);
        if (MSB_FIRST) return 16'((i / 4) * 4 + 3 - (i % 4));
        return 16'(i);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus.wr_data        = '0;
        bus.wr_en          = 1'b0;
        bus.clr_overflow   = 1'b0;
        bus.write_not_busy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("init_idle", bus.idle, 1'b1);
        chk("init_wr_full", bus.wr_full, 1'b0);

        // Single word, transmitter busy 10 cycles after every strobe.
        wnb_mode = 1;
        clear_logs();
        push(32'h44332211);
        wait_strobes(4, 200, "t2");
        for (int i = 0; i < 4; i++) begin
            chk("t2_byte", strobe_dat[i], MSB_FIRST ? 16'(8'h11 * (4 - i)) : 16'(8'h11 * (i + 1)));
        end
        chk("t2_first_latency", strobe_cyc[0] - push_cyc[0], 3);
        chk("t2_spacing", strobe_cyc[1] - strobe_cyc[0], 12);
        repeat (20) tick();
        chk("t2_idle_after", bus.idle, 1'b1);

        // Stalled transmitter: fill the FIFO, overflow, clear with and without a concurrent reject.
        wnb_mode  = 0;
        wnb_fixed = 1'b0;
        tick();
        clear_logs();
        bus.wr_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus.wr_data = 32'hA0B0C000 + i;
            tick();
        end
        bus.wr_en = 1'b0;
        chk("t3_accepted", push_cyc.size(), 9);
        chk("t3_wr_full", bus.wr_full, 1'b1);
        chk("t3_overflow", bus.overflow, 1'b1);
        bus.wr_en        = 1'b1;
        bus.clr_overflow = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        chk("t3_reject_beats_clear", bus.overflow, 1'b1);
        tick();
        bus.clr_overflow = 1'b0;
        chk("t3_overflow_cleared", bus.overflow, 1'b0);
        wnb_fixed = 1'b1;
        wait_strobes(36, 600, "t3");
        repeat (20) tick();
        chk("t3_strobe_count", strobe_cyc.size(), 36);
        chk("t3_first_byte", strobe_dat[0], MSB_FIRST ? 16'h00A0 : 16'h0001);
        chk("t3_last_byte", strobe_dat[35], MSB_FIRST ? 16'h0009 : 16'h00A0);

        // Asynchronous reset mid-cycle with a full FIFO and overflow set.
        wnb_fixed = 1'b0;
        tick();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wr_data = 32'h5A5A0000 + i;
            tick();
        end
        bus.wr_en = 1'b0;
        chk("t1_pre_overflow", bus.overflow, 1'b1);
        chk("t1_pre_data_out", bus.data_out, MSB_FIRST ? 16'h0009 : 16'h00A0);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_async_overflow", bus.overflow, 1'b0);
        chk("t1_async_wr_full", bus.wr_full, 1'b0);
        chk("t1_async_idle", bus.idle, 1'b1);
        chk("t1_async_data_out", bus.data_out, 16'h0000);
        chk("t1_async_write_enable", bus.write_enable, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        wnb_fixed = 1'b1;

        // Reset after the second strobe discards the rest of the work.
        wnb_mode = 1;
        busy     = 0;
        tick();
        clear_logs();
        push(32'hDEADBEEF);
        push(32'hCAFEF00D);
        wait_strobes(2, 100, "t5");
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_logs();
        repeat (60) tick();
        chk("t5_no_strobes", strobe_cyc.size(), 0);
        chk("t5_idle", bus.idle, 1'b1);

        // Transmitter always ready, three words back-to-back.
        wnb_mode  = 0;
        wnb_fixed = 1'b1;
        tick();
        clear_logs();
        push(32'h03020100);
        push(32'h07060504);
        push(32'h0B0A0908);
        wait_strobes(12, 100, "t6");
        repeat (10) tick();
        chk("t6_strobe_count", strobe_cyc.size(), 12);
        chk("t6_first_latency", strobe_cyc[0] - push_cyc[0], 3);
        for (int i = 0; i < 12; i++) begin
            chk("t6_byte", strobe_dat[i], t6_exp(i));
            if (i > 0) chk("t6_spacing", strobe_cyc[i] - strobe_cyc[i-1], 3);
        end
        chk("t6_idle_after_hold", last_idle_rise - strobe_cyc[11], 2);

        // Randomized traffic against the model.
        wnb_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            bus.wr_data      = $urandom;
            bus.wr_en        = ($urandom_range(0, 2) == 0);
            bus.clr_overflow = ($urandom_range(0, 15) == 0);
            tick();
        end
        bus.wr_en        = 1'b0;
        bus.clr_overflow = 1'b0;
        wnb_mode  = 0;
        wnb_fixed = 1'b1;
        repeat (400) tick();
        chk("rand_drained_idle", bus.idle, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
